// File: rtl/psum_buf_pkg.sv
// psum_buf_pkg: shared constants for the psum buffer (default depth, index width, clear FSM encoding, status bit positions)
package psum_buf_pkg;
  localparam int DEPTH_DEF = 4096;
  localparam int AW = $clog2(DEPTH_DEF);
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_CLEAR = 1'b1;
  localparam int SB_BUSY = 0;
  localparam int SB_CLR_DROP = 1;
  localparam int SB_ENG_OOR = 2;
  localparam int SB_HOST_OOR = 3;
endpackage

// File: rtl/psum_bram_sdp.sv
// psum_bram_sdp: 1W/1R block RAM with a registered read and write-first collision (clk, we/waddr/wdata write port, re/raddr -> rdata read port)
module psum_bram_sdp #(
  parameter int DW = 32,
  parameter int AW = 12,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/psum_buffer_memctrl.sv
// psum_buffer_memctrl: psum buffer with engine port (memctrl0_*), lower-priority host readback (host_*), clear sweep (i_clear_start) and sticky status (o_status)
module psum_buffer_memctrl
  import psum_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = DEPTH_DEF,
  parameter int REG_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] memctrl0_wadd,
  input  logic                  memctrl0_wren,
  input  logic [DATA_WIDTH-1:0] memctrl0_idat,
  input  logic [ADDR_WIDTH-1:0] memctrl0_radd,
  input  logic                  memctrl0_rden,
  output logic [DATA_WIDTH-1:0] memctrl0_odat,
  output logic                  memctrl0_oval,
  input  logic [ADDR_WIDTH-1:0] host_radd,
  input  logic                  host_rreq,
  output logic                  host_rgnt,
  output logic [DATA_WIDTH-1:0] host_odat,
  output logic                  host_oval,
  input  logic                  i_clear_start,
  output logic [REG_WIDTH-1:0]  o_status
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] LAST = (IW+1)'(DEPTH - 1);
  logic state, idle, eng_rd, wr_ok, we, re, rd_oor;
  logic e1, h1, oor1;
  logic err_host_oor, err_eng_oor, err_clr_drop;
  logic [IW:0] cnt;
  logic [ADDR_WIDTH-1:0] ra;
  logic [IW-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:IW] == '0 && {1'b0, a[IW-1:0]} < (IW+1)'(DEPTH);
  endfunction
  assign idle = state == ST_IDLE;
  assign eng_rd = idle & memctrl0_rden;
  assign host_rgnt = host_rreq & ~memctrl0_rden & idle;
  assign wr_ok = idle & memctrl0_wren & in_rng(memctrl0_wadd);
  assign ra = memctrl0_rden ? memctrl0_radd : host_radd;
  assign rd_oor = ~in_rng(ra);
  assign re = eng_rd | host_rgnt;
  // the clear sweep owns the write port for its whole duration
  assign we = ~idle | wr_ok;
  assign waddr = idle ? memctrl0_wadd[IW-1:0] : cnt[IW-1:0];
  assign wdata = idle ? memctrl0_idat : '0;
  always_comb begin
    o_status = '0;
    o_status[SB_BUSY] = ~idle;
    o_status[SB_CLR_DROP] = err_clr_drop;
    o_status[SB_ENG_OOR] = err_eng_oor;
    o_status[SB_HOST_OOR] = err_host_oor;
  end
  psum_bram_sdp #(.DW(DATA_WIDTH), .AW(IW), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(ra[IW-1:0]), .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      e1 <= 1'b0;
      h1 <= 1'b0;
      oor1 <= 1'b0;
      memctrl0_oval <= 1'b0;
      memctrl0_odat <= '0;
      host_oval <= 1'b0;
      host_odat <= '0;
      err_host_oor <= 1'b0;
      err_eng_oor <= 1'b0;
      err_clr_drop <= 1'b0;
    end else begin
      state <= idle ? (i_clear_start ? ST_CLEAR : ST_IDLE) : (cnt == LAST ? ST_IDLE : ST_CLEAR);
      cnt <= idle ? '0 : cnt + (IW+1)'(1);
      e1 <= eng_rd;
      h1 <= host_rgnt;
      oor1 <= re & rd_oor;
      memctrl0_oval <= e1;
      host_oval <= h1;
      if (e1) memctrl0_odat <= oor1 ? '0 : rdata;
      if (h1) host_odat <= oor1 ? '0 : rdata;
      err_eng_oor <= err_eng_oor | (idle & memctrl0_wren & ~in_rng(memctrl0_wadd)) | (eng_rd & rd_oor);
      err_host_oor <= err_host_oor | (host_rgnt & rd_oor);
      err_clr_drop <= err_clr_drop | (~idle & (memctrl0_wren | memctrl0_rden));
    end
  end
endmodule

// File: tb/tb_psum_buffer_memctrl.sv
// tb_psum_buffer_memctrl: directed vector table plus hand sequences for arbitration, clear sweep and reset mid-clear
module tb_psum_buffer_memctrl;
  localparam int DEPTH = 4096;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] memctrl0_wadd, memctrl0_idat, memctrl0_radd, memctrl0_odat;
  logic memctrl0_wren, memctrl0_rden, memctrl0_oval;
  logic [31:0] host_radd, host_odat, o_status;
  logic host_rreq, host_rgnt, host_oval, i_clear_start;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic wren;
    logic [31:0] wadd;
    logic [31:0] idat;
    logic rden;
    logic [31:0] radd;
    logic oval;
    logic [31:0] odat;
    logic [31:0] status;
  } vec_t;
  vec_t v[11];
  always #5 clk = ~clk;
  psum_buffer_memctrl dut (
    .clk(clk), .rst(rst),
    .memctrl0_wadd(memctrl0_wadd), .memctrl0_wren(memctrl0_wren), .memctrl0_idat(memctrl0_idat),
    .memctrl0_radd(memctrl0_radd), .memctrl0_rden(memctrl0_rden),
    .memctrl0_odat(memctrl0_odat), .memctrl0_oval(memctrl0_oval),
    .host_radd(host_radd), .host_rreq(host_rreq), .host_rgnt(host_rgnt),
    .host_odat(host_odat), .host_oval(host_oval),
    .i_clear_start(i_clear_start), .o_status(o_status)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0]  = '{1'b1, 32'd5,    32'hA5A5_0001, 1'b0, 32'd0,          1'b0, 32'h0,          32'h0};
    v[1]  = '{1'b0, 32'd0,    32'h0,         1'b1, 32'd5,          1'b0, 32'h0,          32'h0};
    v[2]  = '{1'b1, 32'd9,    32'h11,        1'b0, 32'd0,          1'b1, 32'hA5A5_0001,  32'h0};
    v[3]  = '{1'b1, 32'd9,    32'h77,        1'b1, 32'd9,          1'b0, 32'h0,          32'h0};
    v[4]  = '{1'b1, 32'd9,    32'h88,        1'b0, 32'd0,          1'b1, 32'h77,         32'h0};
    v[5]  = '{1'b0, 32'd0,    32'h0,         1'b1, 32'd9,          1'b0, 32'h0,          32'h0};
    v[6]  = '{1'b1, 32'd2,    32'h22,        1'b0, 32'd0,          1'b1, 32'h88,         32'h0};
    v[7]  = '{1'b1, DEPTH+2,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000,  1'b0, 32'h0,          32'h4};
    v[8]  = '{1'b0, 32'd0,    32'h0,         1'b1, 32'd2,          1'b1, 32'h0,          32'h4};
    v[9]  = '{1'b0, 32'd0,    32'h0,         1'b0, 32'd0,          1'b1, 32'h22,         32'h4};
    v[10] = '{1'b0, 32'd0,    32'h0,         1'b0, 32'd0,          1'b0, 32'h0,          32'h4};
    rst = 1'b1;
    {memctrl0_wren, memctrl0_rden, host_rreq, i_clear_start} = '0;
    {memctrl0_wadd, memctrl0_idat, memctrl0_radd, host_radd} = '0;
    repeat (3) step();
    chk("rst_eng_oval", 32'(memctrl0_oval), 0);
    chk("rst_eng_odat", memctrl0_odat, 0);
    chk("rst_host_oval", 32'(host_oval), 0);
    chk("rst_host_odat", host_odat, 0);
    chk("rst_status", o_status, 0);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      memctrl0_wren = v[i].wren;
      memctrl0_wadd = v[i].wadd;
      memctrl0_idat = v[i].idat;
      memctrl0_rden = v[i].rden;
      memctrl0_radd = v[i].radd;
      step();
      chk($sformatf("vec%0d_oval", i), 32'(memctrl0_oval), 32'(v[i].oval));
      if (v[i].oval) chk($sformatf("vec%0d_odat", i), memctrl0_odat, v[i].odat);
      chk($sformatf("vec%0d_status", i), o_status, v[i].status);
    end
    memctrl0_wren = 1'b1;
    memctrl0_wadd = 3;
    memctrl0_idat = 32'h33;
    step();
    memctrl0_wren = 1'b0;
    host_rreq = 1'b1;
    host_radd = 3;
    memctrl0_rden = 1'b1;
    memctrl0_radd = 5;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("arb_blocked%0d", k), 32'(host_rgnt), 0);
      step();
      chk($sformatf("arb_host_quiet%0d", k), 32'(host_oval), 0);
    end
    memctrl0_rden = 1'b0;
    #1;
    chk("arb_grant", 32'(host_rgnt), 1);
    step();
    host_rreq = 1'b0;
    chk("arb_eng_oval", 32'(memctrl0_oval), 1);
    chk("arb_eng_odat", memctrl0_odat, 32'hA5A5_0001);
    chk("arb_host_early", 32'(host_oval), 0);
    step();
    chk("arb_host_oval", 32'(host_oval), 1);
    chk("arb_host_odat", host_odat, 32'h33);
    chk("arb_eng_not_misrouted", 32'(memctrl0_oval), 0);
    step();
    chk("arb_host_oval_end", 32'(host_oval), 0);
    for (int a = 0; a < 8; a++) begin
      memctrl0_wren = 1'b1;
      memctrl0_wadd = a;
      memctrl0_idat = 32'h100 + a;
      step();
    end
    memctrl0_wren = 1'b0;
    i_clear_start = 1'b1;
    step();
    i_clear_start = 1'b0;
    begin
      int n;
      logic saw;
      int bad;
      n = 0;
      saw = 1'b0;
      while (o_status[0] && n < DEPTH + 8) begin
        memctrl0_wren = (n == 10);
        memctrl0_rden = (n == 10);
        memctrl0_wadd = 1;
        memctrl0_idat = 32'hDEAD;
        memctrl0_radd = 0;
        if (memctrl0_oval) saw = 1'b1;
        n++;
        step();
      end
      memctrl0_wren = 1'b0;
      memctrl0_rden = 1'b0;
      chk("clr_busy_cycles", n, DEPTH);
      chk("clr_no_oval", 32'(saw), 0);
      chk("clr_status", o_status, 32'h6);
      bad = 0;
      for (int a = 0; a <= DEPTH + 1; a++) begin
        memctrl0_rden = (a < DEPTH);
        memctrl0_radd = a;
        step();
        if (a >= 1 && a <= DEPTH && (!memctrl0_oval || memctrl0_odat != 0)) bad++;
      end
      memctrl0_rden = 1'b0;
      chk("clr_all_zero_bad_count", bad, 0);
    end
    i_clear_start = 1'b1;
    step();
    i_clear_start = 1'b0;
    repeat (99) step();
    chk("rstclr_busy", 32'(o_status[0]), 1);
    rst = 1'b1;
    host_rreq = 1'b1;
    host_radd = 0;
    step();
    rst = 1'b0;
    #1;
    chk("rstclr_status", o_status, 0);
    chk("rstclr_rgnt", 32'(host_rgnt), 1);
    step();
    host_rreq = 1'b0;
    step();
    chk("rstclr_host_oval", 32'(host_oval), 1);
    chk("rstclr_host_odat", host_odat, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
